aes256_inv_round_ctrl: RTL

- Iterative AES-256 decryption round sequencer; owns the 128-bit state register and the round counter.
- Drives the external combinational inverse-round datapath (InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns) once per cycle.
- Fetches round keys by index from the key-schedule bank.
- Sits between the ciphertext source and the plaintext sink, with valid/ready on both sides.

---
 rtl/aes256_inv_round_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/aes256_inv_round_ctrl.sv
// Iterative AES-256 decryption round sequencer: owns the state register and round counter,
// steps an external inverse-round datapath once per cycle. Optional: AES_INV_BACKTOBACK_EN.
module aes256_inv_round_ctrl #(
    parameter int NR  = 14,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    input  logic           key_ready,
    output logic [RKW-1:0] rk_idx,
    input  logic [127:0]   rk_data,
    output logic [127:0]   dp_state,
    output logic [127:0]   dp_key,
    output logic           dp_last,
    input  logic [127:0]   dp_result,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [RKW-1:0] FIRST_KEY  = RKW'(NR);
    localparam logic [RKW-1:0] FIRST_RND  = RKW'(NR - 1);
    localparam logic [RKW-1:0] LAST_RND   = '0;

    fsm_t           fsm_q, fsm_d;
    logic [127:0]   state_q, state_d;
    logic [RKW-1:0] round_q, round_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= FIRST_RND;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // A stalled key bank freezes the whole round: no state, counter or FSM movement.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        round_d   = round_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dp_last   = 1'b0;
        rk_idx    = round_q;
        busy      = 1'b1;

        case (fsm_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = key_ready;
                rk_idx   = FIRST_KEY;
                if (in_valid && key_ready) begin
                    state_d = in_data ^ rk_data;
                    round_d = FIRST_RND;
                    fsm_d   = ROUND;
                end
            end

            ROUND: begin
                dp_last = (round_q == LAST_RND);
                if (key_ready) begin
                    state_d = dp_result;
                    if (round_q == LAST_RND) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q - RKW'(1);
                    end
                end
            end

            DONE: begin
                out_valid = 1'b1;
`ifdef AES_INV_BACKTOBACK_EN
                // The next block may load on the same edge the current result leaves.
                rk_idx   = FIRST_KEY;
                in_ready = out_ready & key_ready;
                if (out_ready) begin
                    if (in_valid && key_ready) begin
                        state_d = in_data ^ rk_data;
                        round_d = FIRST_RND;
                        fsm_d   = ROUND;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
`else
                if (out_ready) begin
                    fsm_d = IDLE;
                end
`endif
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign out_data = state_q;
    assign dp_state = state_q;
    assign dp_key   = rk_data;

endmodule
